cpu_core_mc: RTL and testbench
==============================

// Module: cpu_core_mc
// PURPOSE
//  Parametrised multi-cycle successor of the group's 8-bit single-cycle CPU.
//  Keeps the 32-bit ISA format: opcode[31:24], rd/offset[23:16], rt[15:8], rs/imm[7:0].
//  Adds: configurable data width and register count, a fetch handshake to a slow instruction memory,
//  bne, halt, an illegal-opcode flag, a retire strobe, and optional shift ops.
//  Sits between the instruction memory model and the testbench.
// PARAMETERS
//  DATA_W  8   register/ALU width (>=8)
//  NREGS   8   register count, power of two, 2..256; index = low log2(NREGS) bits of field
//  PC_W    32  program counter width; all PC arithmetic modulo 2^PC_W
// PORTS
//  CLK          in   1       clock; all state updates on posedge
//  RESET        in   1       synchronous, active-high
//  PC           out  PC_W    address of instruction being fetched/executed
//  INSTR_REQ    out  1       fetch request, high in FETCH
//  INSTRUCTION  in   32      instruction word; sampled only when INSTR_REQ & INSTR_VALID
//  INSTR_VALID  in   1       imem ack: INSTRUCTION holds word for PC
//  RETIRED      out  1       one-cycle pulse per completed instruction
//  HALTED       out  1       high in HALT state
//  ILLEGAL      out  1       sticky: an undefined opcode was executed
//  DBG_RADDR    in   log2(NREGS)  debug read index
//  DBG_RDATA    out  DATA_W  combinational regfile[DBG_RADDR]
// BEHAVIOUR
//  Reset (any state, any cycle): state=FETCH, PC=0, IR=0, all regs=0, RETIRED=0, HALTED=0, ILLEGAL=0;
//   an INSTR_VALID in the reset cycle is ignored.
//  FSM FETCH -> EXEC -> FETCH; EXEC -> HALT on opcode 0xFF; HALT exits only via RESET.
//  FETCH: INSTR_REQ=1, PC stable; wait any number of cycles; on INSTR_VALID latch IR, go EXEC.
//   INSTR_VALID outside FETCH is ignored.
//  EXEC (exactly 1 cycle): A=reg[rt], B=reg[rs], IMM=zero-extended imm[7:0];
//   at the closing edge: write rd (if writing op), update PC, RETIRED=1 for the next cycle.
//  Min latency: 2 cycles/instruction; n wait cycles in FETCH add n.
//  Opcodes:
//   00 loadi rd=IMM;  01 mov rd=B;  02 add rd=A+B;  03 sub rd=A-B;  04 and;  05 or
//   06 j    PC=PC+4+(sext(offset)<<2)
//   07 beq  taken if A==B
//   08 bne  taken if A!=B; not taken PC=PC+4
//   FF halt no write, PC unchanged, enter HALT
//  Arithmetic: DATA_W wrap-around, no flags; offset sign-extended from 8 bits to PC_W.
//  Non-branch ops: PC=PC+4.
//  Write to rd and read of the same reg in one instruction: read sees the old value.
//  Undefined opcode: behaves as NOP (PC+4, no write), sets ILLEGAL, RETIRED still pulses.
//  Halt: RETIRED pulses once; HALTED=1 from the next cycle; INSTR_REQ=0.
// CONFIGURATION
//  CPU_SHIFT_EN defined:
//   0A sll  rd=A<<imm;  0B srl  rd=A>>imm (zero fill);  0C sra (sign fill)
//   imm>=DATA_W: sll/srl give 0, sra gives all sign bits
//  CPU_SHIFT_EN undefined: 0A-0C are undefined opcodes (NOP + ILLEGAL).
// TESTING
//  1 Reset mid-FETCH with INSTR_VALID=1 -> next cycle PC=0, INSTR_REQ=1, regs 0, no RETIRED.
//  2 DATA_W=8: loadi r1,0xFF; loadi r2,0x02; add r3,r1,r2; sub r4,r2,r1
//    -> r3=0x01, r4=0x03; 4 RETIRED pulses in 8 cycles (VALID always 1).
//  3 VALID delayed 3 cycles per fetch -> PC and INSTR_REQ stable while waiting;
//    each instruction takes 5 cycles; results identical to scenario 2.
//  4 PC=0x10: beq offset 0xFE with r1==r2 -> PC=0x0C; bne on the same regs -> PC=0x14;
//    j offset 0x01 -> PC+8.
//  5 Opcode 0x3C at PC=0x08 -> ILLEGAL=1, PC=0x0C, no reg change;
//    then 0xFF -> HALTED=1, INSTR_REQ=0, PC frozen.
//  6 DATA_W=16, CPU_SHIFT_EN: r1=0x8001; sra imm 4 -> 0xF800; srl imm 16 -> 0x0000.
//    Without the macro: 0x0B sets ILLEGAL, r unchanged.

Source files
------------

// File: rtl/cpu_core_mc_if.sv
// Fetch port between cpu_core_mc and its instruction memory.
// master = core side, slave = memory side.
interface cpu_core_mc_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] PC;
  logic            INSTR_REQ;
  logic [31:0]     INSTRUCTION;
  logic            INSTR_VALID;

  modport master (
    output PC,
    output INSTR_REQ,
    input  INSTRUCTION,
    input  INSTR_VALID
  );

  modport slave (
    input  PC,
    input  INSTR_REQ,
    output INSTRUCTION,
    output INSTR_VALID
  );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH/EXEC/HALT, parametrised width and regs.
// Optional shift ops (0A sll, 0B srl, 0C sra) when CPU_SHIFT_EN is defined.
module cpu_core_mc #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  cpu_core_mc_if.master            imem,
  output logic                     RETIRED,
  output logic                     HALTED,
  output logic                     ILLEGAL,
  input  logic [$clog2(NREGS)-1:0] DBG_RADDR,
  output logic [DATA_W-1:0]        DBG_RDATA
);
  localparam int IW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  logic [7:0]        op, off8, imm8;
  logic [IW-1:0]     rd, rt, rs;
  logic [DATA_W-1:0] a, b, imm;
  logic [PC_W-1:0]   pc_seq, pc_br;

  assign op   = ir_q[31:24];
  assign off8 = ir_q[23:16];
  assign imm8 = ir_q[7:0];
  assign rd   = ir_q[16+:IW];
  assign rt   = ir_q[8+:IW];
  assign rs   = ir_q[0+:IW];

  assign a   = regs_q[rt];
  assign b   = regs_q[rs];
  assign imm = DATA_W'(imm8);

  assign pc_seq = pc_q + PC_W'(4);
  assign pc_br  = pc_seq + (PC_W'(signed'(off8)) << 2);

  // Sequencing, execute datapath and next PC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = 1'b0;
    illegal_d = illegal_q;
    wr_en     = 1'b0;
    wr_data   = '0;
    unique case (state_q)
      S_FETCH: begin
        if (imem.INSTR_VALID) begin
          ir_d    = imem.INSTRUCTION;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        retired_d = 1'b1;
        state_d   = S_FETCH;
        pc_d      = pc_seq;
        case (op)
          8'h00: begin wr_en = 1'b1; wr_data = imm;   end
          8'h01: begin wr_en = 1'b1; wr_data = b;     end
          8'h02: begin wr_en = 1'b1; wr_data = a + b; end
          8'h03: begin wr_en = 1'b1; wr_data = a - b; end
          8'h04: begin wr_en = 1'b1; wr_data = a & b; end
          8'h05: begin wr_en = 1'b1; wr_data = a | b; end
          8'h06: pc_d = pc_br;
          8'h07: if (a == b) pc_d = pc_br;
          8'h08: if (a != b) pc_d = pc_br;
`ifdef CPU_SHIFT_EN
          // Shift amounts >= DATA_W fall out of the shift semantics.
          8'h0A: begin wr_en = 1'b1; wr_data = a << imm8; end
          8'h0B: begin wr_en = 1'b1; wr_data = a >> imm8; end
          8'h0C: begin
            wr_en   = 1'b1;
            wr_data = $signed(a) >>> imm8;
          end
`endif
          8'hFF: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, PC, IR, flags and register file update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      if (wr_en) regs_q[rd] <= wr_data;
    end
  end

  assign imem.PC        = pc_q;
  assign imem.INSTR_REQ = (state_q == S_FETCH);
  assign RETIRED        = retired_q;
  assign HALTED         = (state_q == S_HALT);
  assign ILLEGAL        = illegal_q;
  assign DBG_RDATA      = regs_q[DBG_RADDR];

  logic unused_ok;
  assign unused_ok = ^ir_q[15:8];
endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: directed scenarios plus random programs
// checked against a behavioural ISA model.
module tb_cpu_core_mc;
  localparam int DW  = 8;
  localparam int NR  = 8;
  localparam int MOD = 1 << DW;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RETIRED, HALTED, ILLEGAL;
  logic [2:0] DBG_RADDR;
  logic [7:0] DBG_RDATA;

  cpu_core_mc_if #(.PC_W(32)) bus ();

  cpu_core_mc #(.DATA_W(DW), .NREGS(NR), .PC_W(32)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .imem      (bus),
    .RETIRED   (RETIRED),
    .HALTED    (HALTED),
    .ILLEGAL   (ILLEGAL),
    .DBG_RADDR (DBG_RADDR),
    .DBG_RDATA (DBG_RDATA)
  );

  always #10 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rcnt  = 0;

  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (RETIRED === 1'b1) rcnt++;

  int unsigned m_regs [NR];
  logic [31:0] m_pc;
  bit          m_ill;
  bit          m_halt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int d,
                                      input int t, input int s);
    enc = {op[7:0], d[7:0], t[7:0], s[7:0]};
  endfunction

  task automatic rd_reg(input int i, output logic [7:0] v);
    DBG_RADDR = i[2:0];
    #1;
    v = DBG_RDATA;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] v;
    for (int i = 0; i < NR; i++) begin
      rd_reg(i, v);
      chk($sformatf("%s_r%0d", tag, i), 64'(v), 64'(m_regs[i]));
    end
  endtask

  // ISA reference: computes architectural effect of one instruction.
  task automatic model_step(input logic [31:0] w);
    int unsigned a, b, imm, res, rd;
    int          off, sa;
    bit          wr;
    logic [7:0]  op;
    op  = w[31:24];
    rd  = w[23:16] % NR;
    a   = m_regs[w[15:8] % NR];
    b   = m_regs[w[7:0] % NR];
    imm = w[7:0];
    off = int'(w[23:16]);
    if (off > 127) off -= 256;
    wr  = 1'b1;
    res = 0;
    m_pc_next: begin end
    case (op)
      8'h00: res = imm % MOD;
      8'h01: res = b;
      8'h02: res = (a + b) % MOD;
      8'h03: res = (a + MOD - b) % MOD;
      8'h04: res = a & b;
      8'h05: res = a | b;
      8'h06: wr = 1'b0;
      8'h07: wr = 1'b0;
      8'h08: wr = 1'b0;
`ifdef CPU_SHIFT_EN
      8'h0A: res = (imm >= DW) ? 0 : (a << imm) % MOD;
      8'h0B: res = (imm >= DW) ? 0 : (a >> imm);
      8'h0C: begin
        sa = (a >= MOD / 2) ? int'(a) - MOD : int'(a);
        if (imm >= DW) res = (sa < 0) ? MOD - 1 : 0;
        else           res = (sa >>> imm) & (MOD - 1);
      end
`endif
      8'hFF: wr = 1'b0;
      default: begin wr = 1'b0; m_ill = 1'b1; end
    endcase
    if (op == 8'hFF) m_halt = 1'b1;
    else if (op == 8'h06 || (op == 8'h07 && a == b) ||
             (op == 8'h08 && a != b))
      m_pc = m_pc + 32'(4 + off * 4);
    else
      m_pc = m_pc + 32'd4;
    if (wr) m_regs[rd] = res;
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_pc   = 0;
    m_ill  = 0;
    m_halt = 0;
  endtask

  // Called at a negedge; leaves the DUT one cycle out of reset.
  task automatic do_reset(input bit vld);
    RESET           = 1'b1;
    bus.INSTR_VALID = vld;
    bus.INSTRUCTION = enc(0, 5, 0, 8'h5A);
    @(posedge CLK);
    @(negedge CLK);
    RESET           = 1'b0;
    bus.INSTR_VALID = 1'b0;
    model_reset();
    chk("rst_pc", 64'(bus.PC), 0);
    chk("rst_req", 64'(bus.INSTR_REQ), 1);
    chk("rst_ret", 64'(RETIRED), 0);
    chk("rst_halt", 64'(HALTED), 0);
    chk("rst_ill", 64'(ILLEGAL), 0);
    check_regs("rst");
  endtask

  // Fetch one word after `waits` idle cycles, then execute it.
  task automatic exec_one(input logic [31:0] w, input int waits);
    chk("f_req", 64'(bus.INSTR_REQ), 1);
    chk("f_pc", 64'(bus.PC), 64'(m_pc));
    for (int i = 0; i < waits; i++) begin
      bus.INSTR_VALID = 1'b0;
      bus.INSTRUCTION = $urandom;
      @(posedge CLK);
      @(negedge CLK);
      chk("w_pc", 64'(bus.PC), 64'(m_pc));
      chk("w_req", 64'(bus.INSTR_REQ), 1);
      chk("w_ret", 64'(RETIRED), 0);
    end
    bus.INSTRUCTION = w;
    bus.INSTR_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.INSTRUCTION = $urandom;
    chk("x_req", 64'(bus.INSTR_REQ), 0);
    chk("x_ret", 64'(RETIRED), 0);
    model_step(w);
    @(posedge CLK);
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    chk("r_ret", 64'(RETIRED), 1);
    chk("r_pc", 64'(bus.PC), 64'(m_pc));
    chk("r_ill", 64'(ILLEGAL), 64'(m_ill));
    chk("r_halt", 64'(HALTED), 64'(m_halt));
    chk("r_req", 64'(bus.INSTR_REQ), 64'(!m_halt));
    check_regs("r");
  endtask

  task automatic prog2(input int waits);
    exec_one(enc(8'h00, 1, 0, 8'hFF), waits);
    exec_one(enc(8'h00, 2, 0, 8'h02), waits);
    exec_one(enc(8'h02, 3, 1, 2), waits);
    exec_one(enc(8'h03, 4, 2, 1), waits);
  endtask

  initial begin
    int          c0, r0, op, w8;
    logic [7:0]  v;
    logic [31:0] w;
    logic [31:0] hpc;
    RESET           = 1'b1;
    bus.INSTR_VALID = 1'b0;
    bus.INSTRUCTION = '0;
    DBG_RADDR       = '0;
    model_reset();
    @(negedge CLK);
    do_reset(1'b0);

    c0 = cyc; r0 = rcnt;
    prog2(0);
    chk("s2_cycles", 64'(cyc - c0), 8);
    chk("s2_retires", 64'(rcnt - r0), 4);
    rd_reg(3, v); chk("s2_r3", 64'(v), 64'h01);
    rd_reg(4, v); chk("s2_r4", 64'(v), 64'h03);

    do_reset(1'b1);
    @(posedge CLK);
    @(negedge CLK);
    chk("s1_req", 64'(bus.INSTR_REQ), 1);
    chk("s1_pc", 64'(bus.PC), 0);
    chk("s1_ret", 64'(RETIRED), 0);

    c0 = cyc;
    prog2(3);
    chk("s3_cycles", 64'(cyc - c0), 20);
    rd_reg(3, v); chk("s3_r3", 64'(v), 64'h01);
    rd_reg(4, v); chk("s3_r4", 64'(v), 64'h03);

    do_reset(1'b0);
    exec_one(enc(8'h00, 1, 0, 5), 0);
    exec_one(enc(8'h00, 2, 0, 5), 1);
    exec_one(enc(8'h00, 3, 0, 0), 0);
    exec_one(enc(8'h00, 4, 0, 0), 2);
    exec_one(enc(8'h07, 8'hFE, 1, 2), 0);
    chk("s4_beq", 64'(bus.PC), 64'h0C);
    exec_one(enc(8'h08, 8'hFE, 1, 2), 0);
    chk("s4_bne", 64'(bus.PC), 64'h10);
    exec_one(enc(8'h06, 8'h01, 0, 0), 0);
    chk("s4_j", 64'(bus.PC), 64'h18);

    do_reset(1'b0);
    exec_one(enc(8'h00, 1, 0, 8'h81), 0);
    exec_one(enc(8'h0C, 2, 1, 4), 0);
    exec_one(enc(8'h0B, 3, 1, 8), 0);
    exec_one(enc(8'h0A, 4, 1, 1), 0);
`ifdef CPU_SHIFT_EN
    rd_reg(2, v); chk("sh_sra", 64'(v), 64'hF8);
    rd_reg(3, v); chk("sh_srl", 64'(v), 64'h00);
    rd_reg(4, v); chk("sh_sll", 64'(v), 64'h02);
    chk("sh_ill", 64'(ILLEGAL), 0);
`else
    rd_reg(2, v); chk("sh_r2", 64'(v), 64'h00);
    chk("sh_ill", 64'(ILLEGAL), 1);
`endif

    do_reset(1'b0);
    exec_one(enc(8'h00, 1, 0, 7), 0);
    exec_one(enc(8'h00, 2, 0, 9), 0);
    exec_one(enc(8'h3C, 1, 1, 2), 0);
    chk("s5_ill", 64'(ILLEGAL), 1);
    chk("s5_pc", 64'(bus.PC), 64'h0C);
    rd_reg(1, v); chk("s5_r1", 64'(v), 64'h07);
    exec_one(enc(8'hFF, 0, 0, 0), 1);
    chk("s5_halt", 64'(HALTED), 1);
    hpc = bus.PC;
    chk("s5_hpc", 64'(hpc), 64'h0C);
    for (int i = 0; i < 4; i++) begin
      bus.INSTR_VALID = 1'b1;
      bus.INSTRUCTION = enc(8'h00, 1, 0, 8'h33);
      @(posedge CLK);
      @(negedge CLK);
      chk("h_halt", 64'(HALTED), 1);
      chk("h_req", 64'(bus.INSTR_REQ), 0);
      chk("h_ret", 64'(RETIRED), 0);
      chk("h_pc", 64'(bus.PC), 64'(hpc));
    end
    rd_reg(1, v); chk("h_r1", 64'(v), 64'h07);

    do_reset(1'b0);
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 13);
      if (op == 9)       w8 = 8'h09;
      else if (op >= 10 && op <= 12) w8 = 8'h0A + (op - 10);
      else if (op == 13) w8 = $urandom_range(8'h0D, 8'hFE);
      else               w8 = op;
      w = $urandom;
      w[31:24] = w8[7:0];
      exec_one(w, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
